// File: rtl/dff_deser_pkg.sv
// dff_deser_pkg: shared width default and FSM state type for the deserializer.
package dffx;
  localparam int dff_bits_count = 8;
  typedef enum logic {COLLECT, HOLD} deser_state_e;
endpackage

// File: rtl/dff_deser_if.sv
// dff_deser_if: serial-in / word-out handshake bundle of the deserializer.
interface dff_deser_if import dffx::*; #(parameter int BITS_COUNT = dff_bits_count);
  logic flush;
  logic ser_valid;
  logic ser_data;
  logic ser_ready;
  logic par_valid;
  logic par_ready;
  logic [BITS_COUNT-1:0] par_data;
  logic [7:0] word_count;
  logic parity_err;
  modport master (output flush, ser_valid, ser_data, par_ready,
                  input ser_ready, par_valid, par_data, word_count, parity_err);
  modport slave (input flush, ser_valid, ser_data, par_ready,
                 output ser_ready, par_valid, par_data, word_count, parity_err);
endinterface

// File: rtl/dff_deser.sv
// dff_deser: bit-serial to word-parallel deserializer with held output word.
// Define DFF_DESER_PARITY_EN to expect a trailing even-parity bit per word.
module dff_deser import dffx::*; #(
  parameter int BITS_COUNT = dff_bits_count,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  dff_deser_if.slave bus
);
`ifdef DFF_DESER_PARITY_EN
  localparam logic [6:0] LAST = 7'(BITS_COUNT);
`else
  localparam logic [6:0] LAST = 7'(BITS_COUNT - 1);
`endif
  deser_state_e state;
  logic [6:0] cnt;
  logic [BITS_COUNT-1:0] sreg, word, par_data;
  logic par_valid, perr;
  logic [7:0] word_count;
  assign word = MSB_FIRST ? {sreg[BITS_COUNT-2:0], bus.ser_data} : {bus.ser_data, sreg[BITS_COUNT-1:1]};
  assign bus.ser_ready = state == COLLECT;
  assign bus.par_valid = par_valid;
  assign bus.par_data = par_data;
  assign bus.word_count = word_count;
  assign bus.parity_err = perr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= COLLECT;
      cnt <= '0;
      sreg <= '0;
      par_data <= '0;
      par_valid <= 1'b0;
      word_count <= '0;
      perr <= 1'b0;
    end else begin
      perr <= 1'b0;
      if (state == HOLD) begin
        if (bus.par_ready) begin
          state <= COLLECT;
          par_valid <= 1'b0;
          word_count <= word_count + 8'd1;
        end
      end else if (bus.flush) begin
        cnt <= '0;
        sreg <= '0;
      end else if (bus.ser_valid) begin
        if (cnt == LAST) begin
          cnt <= '0;
          sreg <= '0;
`ifdef DFF_DESER_PARITY_EN
          // the parity bit is not shifted in; sreg already holds the data bits
          if ((^sreg) == bus.ser_data) begin
            par_data <= sreg;
            par_valid <= 1'b1;
            state <= HOLD;
          end else perr <= 1'b1;
`else
          par_data <= word;
          par_valid <= 1'b1;
          state <= HOLD;
`endif
        end else begin
          cnt <= cnt + 7'd1;
          sreg <= word;
        end
      end
    end
endmodule

// File: tb/tb_dff_deser.sv
// tb_dff_deser: directed + random bench for dff_deser against a bit-queue model.
module tb_dff_deser;
  localparam int N = 8;
`ifdef DFF_DESER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dff_deser_if #(.BITS_COUNT(N)) b0 ();
  dff_deser_if #(.BITS_COUNT(N)) b1 ();
  dff_deser #(.BITS_COUNT(N), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(b0.slave));
  dff_deser #(.BITS_COUNT(N), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(b1.slave));
  int checks = 0;
  int passes = 0;
  bit q[$];
  bit hold = 0;
  bit perr = 0;
  logic [7:0] wc = '0;
  logic [7:0] em = '0;
  logic [7:0] el = '0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  task automatic drive(bit sv, bit sd, bit pr, bit fl);
    b0.ser_valid = sv; b0.ser_data = sd; b0.par_ready = pr; b0.flush = fl;
    b1.ser_valid = sv; b1.ser_data = sd; b1.par_ready = pr; b1.flush = fl;
  endtask
  task automatic observe();
    check("ser_ready_msb", b0.ser_ready, !hold);
    check("ser_ready_lsb", b1.ser_ready, !hold);
    check("par_valid_msb", b0.par_valid, hold);
    check("par_valid_lsb", b1.par_valid, hold);
    check("word_count", b0.word_count, wc);
    check("parity_err", b0.parity_err, perr);
    if (hold) begin
      check("par_data_msb", b0.par_data, em);
      check("par_data_lsb", b1.par_data, el);
    end
  endtask
  // one word per N data bits (+ parity bit); first bit is word MSB or LSB
  task automatic model(bit sv, bit sd, bit pr, bit fl);
    int ones;
    perr = 0;
    if (hold) begin
      if (pr) begin hold = 0; wc = wc + 8'd1; end
    end else if (fl) q.delete();
    else if (sv) begin
      q.push_back(sd);
      if (q.size() == N + PB) begin
        ones = 0;
        for (int i = 0; i < N; i++) begin
          em[N-1-i] = q[i];
          el[i] = q[i];
          ones += int'(q[i]);
        end
        if (PB == 0 || (ones % 2) == int'(q[N])) hold = 1;
        else perr = 1;
        q.delete();
      end
    end
  endtask
  task automatic cyc(bit sv, bit sd, bit pr, bit fl);
    drive(sv, sd, pr, fl);
    @(posedge clk);
    model(sv, sd, pr, fl);
    @(negedge clk);
    observe();
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    q.delete(); hold = 0; perr = 0; wc = '0;
    #1;
    observe();
    check("reset_par_data", b0.par_data, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic send_word(logic [7:0] v, bit pr, bit badpar);
    for (int i = N - 1; i >= 0; i--) cyc(1, v[i], pr, 0);
    if (PB == 1) cyc(1, (^v) ^ badpar, pr, 0);
  endtask
  initial begin
    drive(0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    send_word(8'hA5, 1, 0);
    check("a5_valid", b0.par_valid, 1);
    check("a5_msb", b0.par_data, 8'hA5);
    check("a5_lsb", b1.par_data, 8'hA5);
    cyc(0, 0, 1, 0);
    check("a5_handoff_count", b0.word_count, 1);
    send_word(8'h80, 1, 0);
    check("lsb_first_01", b1.par_data, 8'h01);
    cyc(0, 0, 1, 0);
    send_word(8'h5A, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("bp_ready_low", b0.ser_ready, 0);
    check("bp_data_held", b0.par_data, 8'h5A);
    cyc(0, 0, 1, 0);
    check("bp_ready_back", b0.ser_ready, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 1);
    send_word(8'h3C, 1, 0);
    check("flush_3c", b0.par_data, 8'h3C);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0);
    do_reset();
    send_word(8'hFF, 1, 0);
    check("post_reset_ff", b0.par_data, 8'hFF);
    check("post_reset_count", b0.word_count, 0);
    cyc(0, 0, 1, 0);
`ifdef DFF_DESER_PARITY_EN
    send_word(8'h07, 1, 1);
    check("parity_bad_pulse", b0.parity_err, 1);
    check("parity_bad_novalid", b0.par_valid, 0);
    cyc(0, 0, 1, 0);
    send_word(8'h07, 1, 0);
    check("parity_ok_07", b0.par_data, 8'h07);
    cyc(0, 0, 1, 0);
`endif
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_word(8'($urandom), 1, 0);
      cyc(0, 0, 1, 0);
    end
    check("count_wrap", b0.word_count, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
